// File: rtl/reverse_bridge.sv
// reverse_bridge: converts a 4-phase req/ack transfer into a valid/ready
// stream through a DEPTH-entry first-word-fall-through FIFO.
//
// Ports:
//   clk       in   single clock, rising edge
//   rst       in   asynchronous active-low reset
//   en        in   capture enable for the req/ack side
//   req       in   4-phase request from upstream initiator
//   data_in   in   upstream data, stable while req=1
//   ack       out  4-phase acknowledge (decode of the handshake state flop)
//   valid     out  downstream data available (level != 0), registered
//   ready     in   downstream accepts data
//   data_out  out  oldest buffered entry, 0 when empty, registered
//   level     out  buffer occupancy, registered
module reverse_bridge #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         req,
    input  logic [WIDTH-1:0]             data_in,
    output logic                         ack,
    output logic                         valid,
    input  logic                         ready,
    output logic [WIDTH-1:0]             data_out,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH + 1);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACK_HI = 1'b1
    } hs_state_e;

    hs_state_e           state_q, state_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]       level_q, level_d;
    logic                valid_q, valid_d;
    logic [WIDTH-1:0]    data_out_q, data_out_d;
    logic [WIDTH-1:0]    mem_q [DEPTH];

    logic                push;
    logic                pop;
    logic                head_is_new;

    // Handshake state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Handshake next state; the full check uses the registered level only,
    // so a pop on the same edge never lets a push through at level==DEPTH
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en && req && (level_q < LW'(DEPTH))) begin
                    push    = 1'b1;
                    state_d = ACK_HI;
                end
            end
            ACK_HI: begin
                // en is ignored here: an accepted handshake always completes
                if (!req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs
    always_comb begin
        ack = (state_q == ACK_HI);
    end

    // FIFO pointers, occupancy and next head-of-buffer
    always_comb begin
        pop      = valid_q && ready;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;

        if (push) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end

        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        // The entry being written this edge becomes the head when the
        // buffer is (or is about to be) empty; storage is not yet updated.
        head_is_new = push && ((level_q == '0) || ((level_q == LW'(1)) && pop));

        valid_d = (level_d != '0);
        if (level_d == '0) begin
            data_out_d = '0;
        end else if (head_is_new) begin
            data_out_d = data_in;
        end else begin
            data_out_d = mem_q[rd_ptr_d];
        end
    end

    // FIFO control registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            valid_q    <= 1'b0;
            data_out_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            valid_q    <= valid_d;
            data_out_q <= data_out_d;
        end
    end

    // Buffer storage; contents survive reset, pointers make them invisible
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign valid    = valid_q;
    assign data_out = data_out_q;
    assign level    = level_q;

endmodule

// File: tb/tb_reverse_bridge.sv
module tb_reverse_bridge;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             req;
    logic [WIDTH-1:0] data_in;
    logic             ack;
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data_out;
    logic [2:0]       level;

    reverse_bridge #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .req      (req),
        .data_in  (data_in),
        .ack      (ack),
        .valid    (valid),
        .ready    (ready),
        .data_out (data_out),
        .level    (level)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    // Reference model: a queue of accepted words plus a "handshake open" bit
    logic [7:0] mq[$];
    bit         m_hs;
    logic [7:0] pops[$];
    bit         toggle_ready;

    typedef struct {
        logic       en;
        logic       req;
        logic [7:0] din;
        logic       rdy;
        logic       e_ack;
        logic       e_valid;
        logic [7:0] e_data;
        int         e_level;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit do_pop, do_push;
        if (!rst) begin
            mq.delete();
            m_hs = 1'b0;
        end else begin
            do_pop  = (mq.size() != 0) && ready;
            do_push = !m_hs && en && req && (mq.size() < DEPTH);
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back(data_in);
            if (m_hs && !req) m_hs = 1'b0;
            else if (do_push)  m_hs = 1'b1;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".ack"},   int'(ack),      int'(m_hs));
        chk({tag, ".valid"}, int'(valid),    int'(mq.size() != 0));
        chk({tag, ".data"},  int'(data_out), (mq.size() != 0) ? int'(mq[0]) : 0);
        chk({tag, ".level"}, int'(level),    mq.size());
    endtask

    // One clock: log pops, advance DUT and model, compare at the falling edge
    task automatic step();
        if (valid && ready) pops.push_back(data_out);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model("model");
        if (toggle_ready) ready = ~ready;
    endtask

    task automatic xfer(input logic [7:0] d);
        int n;
        req = 1'b1;
        data_in = d;
        n = 0;
        while (!ack && n < 40) begin step(); n++; end
        chk("xfer_ack_rise", int'(ack), 1);
        req = 1'b0;
        n = 0;
        while (ack && n < 40) begin step(); n++; end
        chk("xfer_ack_fall", int'(ack), 0);
    endtask

    task automatic drain();
        int n;
        toggle_ready = 1'b0;
        ready = 1'b1;
        n = 0;
        while (valid && n < 40) begin step(); n++; end
        chk("drain_empty", int'(valid), 0);
        ready = 1'b0;
    endtask

    initial begin
        //               en    req   din    rdy   ack   val   data   lvl
        vecs[0] = '{1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1};
        vecs[1] = '{1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 1};
        vecs[2] = '{1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 0};
        vecs[3] = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h00, 0};
        vecs[4] = '{1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b1, 8'h3C, 1};
        vecs[5] = '{1'b0, 1'b1, 8'h77, 1'b0, 1'b1, 1'b1, 8'h3C, 1};
        vecs[6] = '{1'b0, 1'b0, 8'h77, 1'b0, 1'b0, 1'b1, 8'h3C, 1};
        vecs[7] = '{1'b1, 1'b1, 8'h5A, 1'b1, 1'b1, 1'b1, 8'h5A, 1};
        vecs[8] = '{1'b1, 1'b0, 8'h5A, 1'b1, 1'b0, 1'b0, 8'h00, 0};
        vecs[9] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 0};

        toggle_ready = 1'b0;
        m_hs = 1'b0;
        rst = 1'b0; en = 1'b0; req = 1'b0; data_in = '0; ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset.ack",   int'(ack),      0);
        chk("reset.valid", int'(valid),    0);
        chk("reset.data",  int'(data_out), 0);
        chk("reset.level", int'(level),    0);
        rst = 1'b1;

        // Directed table
        foreach (vecs[i]) begin
            en = vecs[i].en; req = vecs[i].req; data_in = vecs[i].din; ready = vecs[i].rdy;
            step();
            chk($sformatf("vec%0d.ack", i),   int'(ack),      int'(vecs[i].e_ack));
            chk($sformatf("vec%0d.valid", i), int'(valid),    int'(vecs[i].e_valid));
            chk($sformatf("vec%0d.data", i),  int'(data_out), int'(vecs[i].e_data));
            chk($sformatf("vec%0d.level", i), int'(level),    vecs[i].e_level);
        end
        ready = 1'b0;

        // Fill to DEPTH, fifth request held off until a pop frees a slot
        en = 1'b1;
        for (int i = 1; i <= 4; i++) xfer(8'(i));
        chk("fill.level", int'(level), 4);
        req = 1'b1; data_in = 8'h05;
        repeat (3) step();
        chk("fill.held_ack",   int'(ack),   0);
        chk("fill.held_level", int'(level), 4);
        pops.delete();
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk("fill.pop_data",  (pops.size() == 1) ? int'(pops[0]) : -1, 8'h01);
        chk("fill.pop_ack",   int'(ack),   0);
        chk("fill.pop_level", int'(level), 3);
        step();
        chk("fill.late_ack",   int'(ack),   1);
        chk("fill.late_level", int'(level), 4);
        req = 1'b0;
        step();
        pops.delete();
        drain();
        chk("fill.drain_cnt", pops.size(), 4);
        for (int i = 0; i < 4 && i < pops.size(); i++)
            chk($sformatf("fill.drain%0d", i), int'(pops[i]), 2 + i);

        // Order and pointer wrap with ready toggling
        pops.delete();
        ready = 1'b1;
        toggle_ready = 1'b1;
        for (int i = 0; i < 10; i++) xfer(8'(8'h10 + i));
        drain();
        chk("wrap.count", pops.size(), 10);
        for (int i = 0; i < 10 && i < pops.size(); i++)
            chk($sformatf("wrap.order%0d", i), int'(pops[i]), 8'h10 + i);

        // Simultaneous push and pop at level 2
        xfer(8'h31);
        xfer(8'h32);
        chk("simul.pre_level", int'(level), 2);
        req = 1'b1; data_in = 8'h33; ready = 1'b1;
        step();
        chk("simul.level", int'(level),    2);
        chk("simul.data",  int'(data_out), 8'h32);
        chk("simul.ack",   int'(ack),      1);
        req = 1'b0; ready = 1'b0;
        step();
        drain();

        // Long req with en dropped after capture
        en = 1'b1; req = 1'b1; data_in = 8'h44;
        step();
        chk("long.ack0", int'(ack), 1);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            data_in = 8'(8'h90 + i);
            step();
            chk($sformatf("long.ack%0d", i + 1),   int'(ack),   1);
            chk($sformatf("long.level%0d", i + 1), int'(level), 1);
        end
        req = 1'b0;
        step();
        chk("long.ack_fall", int'(ack),      0);
        chk("long.level",    int'(level),    1);
        chk("long.data",     int'(data_out), 8'h44);
        en = 1'b1;
        drain();

        // Asynchronous reset mid-handshake, then recapture of a held req
        xfer(8'h11);
        req = 1'b1; data_in = 8'h22;
        step();
        chk("rst.pre_ack",   int'(ack),   1);
        chk("rst.pre_level", int'(level), 2);
        #2 rst = 1'b0;
        #1;
        chk("rst.async_ack",   int'(ack),      0);
        chk("rst.async_valid", int'(valid),    0);
        chk("rst.async_data",  int'(data_out), 0);
        chk("rst.async_level", int'(level),    0);
        mq.delete();
        m_hs = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("rst.recap_ack",   int'(ack),      1);
        chk("rst.recap_level", int'(level),    1);
        chk("rst.recap_data",  int'(data_out), 8'h22);
        req = 1'b0;
        step();
        drain();

        // Randomized traffic against the model
        for (int i = 0; i < 500; i++) begin
            en      = ($urandom_range(0, 3) != 0);
            ready   = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 2) == 0) req = ~req;
            if (!req || $urandom_range(0, 4) == 0) data_in = 8'($urandom);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
